// File: rtl/lc3_dmem_pkg.sv
// Shared LC3 data-memory types, used by the responder and by the memory-access
// stage that drives dmem_en (mem_state != INIT_STATE).
package lc3_dmem_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_BUS_W = 16;

    typedef enum logic [1:0] {
        READ_MEM       = 2'd0,
        READ_MEM_INDIR = 2'd1,
        WRITE_MEM      = 2'd2,
        INIT_STATE     = 2'd3
    } mem_state_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_fsm_t;

    // True when the address has bits set above the implemented range.
    function automatic logic addr_out_of_range(input logic [ADDR_BUS_W-1:0] addr,
                                               input int unsigned          addr_w);
        return (addr >> addr_w) != '0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// DMem bus between the memory-access stage (master) and the data memory (slave).
interface dmem_responder_if;
    import lc3_dmem_pkg::*;

    logic                  dmem_en;
    logic [ADDR_BUS_W-1:0] DMem_addr;
    logic                  DMem_rd;
    logic [DATA_W-1:0]     DMem_din;
    logic [DATA_W-1:0]     DMem_dout;
    logic                  dmem_ready;
    logic                  addr_err;

    modport master (
        output dmem_en, DMem_addr, DMem_rd, DMem_din,
        input  DMem_dout, dmem_ready, addr_err
    );

    modport slave (
        input  dmem_en, DMem_addr, DMem_rd, DMem_din,
        output DMem_dout, dmem_ready, addr_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: write at the edge, registered read-first output
// that updates every cycle; the caller decides when to use it.
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// LC3 data-memory responder: registered reads held across writes/idle cycles,
// aliasing address error pulse, optional post-reset clear sweep (DMEM_CLEAR_EN).
module dmem_responder
    import lc3_dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    logic              ready;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic              accepted;
    logic              acc_read;
    logic              acc_write;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic              read_pending_reg;
    logic [DATA_W-1:0] dout_hold_reg;
    logic              addr_err_reg;

`ifdef DMEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    dmem_fsm_t         state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              ready_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == CLR_LAST) begin
                        state_reg <= READY;
                        ready_reg <= 1'b1;
                    end
                end
                READY: ;
                default: begin
                    state_reg   <= CLEAR;
                    clr_ptr_reg <= '0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_reg;
    assign clearing = (state_reg == CLEAR);
    assign clr_addr = clr_ptr_reg;
`else
    assign ready    = 1'b1;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign accepted  = bus.dmem_en && ready && !reset;
    assign acc_read  = accepted && bus.DMem_rd;
    assign acc_write = accepted && !bus.DMem_rd;

    // The sweep owns the array port until the FSM reaches READY.
    assign arr_we    = clearing || acc_write;
    assign arr_addr  = clearing ? clr_addr : bus.DMem_addr[ADDR_W-1:0];
    assign arr_wdata = clearing ? '0 : bus.DMem_din;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The array output moves every cycle; only a completed read may show through,
    // otherwise the last value is held so a pointer survives intervening writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            read_pending_reg <= 1'b0;
            dout_hold_reg    <= '0;
            addr_err_reg     <= 1'b0;
        end else begin
            read_pending_reg <= acc_read;
            dout_hold_reg    <= bus.DMem_dout;
            addr_err_reg     <= accepted && addr_out_of_range(bus.DMem_addr, ADDR_W);
        end
    end

    assign bus.DMem_dout  = read_pending_reg ? arr_rdata : dout_hold_reg;
    assign bus.dmem_ready = ready;
    assign bus.addr_err   = addr_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, indirect and reset
// sequences, and randomized traffic against a plain array model.
module tb_dmem_responder;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        en;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    logic [15:0] model_mem [256];
    logic        model_known [256];
    logic [15:0] model_dout;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle's access at the falling edge, sample 1 ns after the rising edge.
    task automatic do_cycle(input logic en, input logic rd, input logic [15:0] addr,
                            input logic [15:0] din);
        @(negedge clock);
        bus.dmem_en   = en;
        bus.DMem_rd   = rd;
        bus.DMem_addr = addr;
        bus.DMem_din  = din;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge clock);
        bus.dmem_en = 1'b0;
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Count rising edges until dmem_ready is seen high, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.dmem_ready !== 1'b1 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] d;
        logic        en;
        logic        rd;
        logic        exp_err;

        total = 0;
        bad   = 0;
        bus.dmem_en   = 1'b0;
        bus.DMem_rd   = 1'b1;
        bus.DMem_addr = '0;
        bus.DMem_din  = '0;
        reset = 1'b1;

        vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h0030, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0030, 16'h1234, 16'hBEEF, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'h0020, 16'h0000, 16'h0030, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h0030, 16'h0000, 16'h1234, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0005, 16'hFFFF, 16'h1234, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0005, 16'h5555, 16'h1234, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0005, 16'hFFFF, 16'h1234, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0005, 16'h0000, 16'h5555, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h0110, 16'h0000, 16'hBEEF, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h0110, 16'h0000, 16'hBEEF, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0210, 16'hCAFE, 16'hBEEF, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 16'h0010, 16'h0000, 16'hCAFE, 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_dout", bus.DMem_dout, 16'h0000);
        chk("reset_err", {15'd0, bus.addr_err}, 16'd0);

`ifdef DMEM_CLEAR_EN
        chk("reset_ready", {15'd0, bus.dmem_ready}, 16'd0);
        // Access during the sweep must be dropped without an error pulse.
        do_cycle(1'b1, 1'b1, 16'h0110, 16'h0000);
        chk("sweep_drop_err", {15'd0, bus.addr_err}, 16'd0);
        chk("sweep_drop_dout", bus.DMem_dout, 16'h0000);
        pulse_reset(2);
        wait_ready(n);
        chk("sweep_len", 16'(n), 16'd256);
        do_cycle(1'b1, 1'b1, 16'h0042, 16'h0000);
        chk("cleared_0042", bus.DMem_dout, 16'h0000);
`else
        chk("reset_ready", {15'd0, bus.dmem_ready}, 16'd1);
`endif

        for (int i = 0; i < 14; i++) begin
            do_cycle(vecs[i].en, vecs[i].rd, vecs[i].addr, vecs[i].din);
            $display("vec %0d en=%0b rd=%0b addr=%h din=%h dout=%h err=%0b", i,
                     vecs[i].en, vecs[i].rd, vecs[i].addr, vecs[i].din,
                     bus.DMem_dout, bus.addr_err);
            chk($sformatf("vec%0d_dout", i), bus.DMem_dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_err", i), {15'd0, bus.addr_err}, {15'd0, vecs[i].exp_err});
        end

        // Indirect: read pointer, feed DMem_dout straight back as the address.
        do_cycle(1'b1, 1'b1, 16'h0020, 16'h0000);
        chk("indir_ptr", bus.DMem_dout, 16'h0030);
        do_cycle(1'b1, 1'b1, bus.DMem_dout, 16'h0000);
        chk("indir_data", bus.DMem_dout, 16'h1234);
        $display("indirect ptr=0020 data=%h", bus.DMem_dout);

        // Randomized traffic against a plain array model.
        for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
        model_dout = bus.DMem_dout;
        for (int i = 0; i < 16; i++) begin
            a = 16'h0040 + 16'(i);
            d = 16'($urandom);
            do_cycle(1'b1, 1'b0, a, d);
            model_mem[a[7:0]]   = d;
            model_known[a[7:0]] = 1'b1;
            chk("rnd_init_dout", bus.DMem_dout, model_dout);
        end
        for (int i = 0; i < 150; i++) begin
            a  = 16'h0040 + 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[15:8] = 8'($urandom_range(1, 255));
            d  = 16'($urandom);
            en = ($urandom_range(0, 4) != 0);
            rd = $urandom_range(0, 1) == 1;
            do_cycle(en, rd, a, d);
            if (en) begin
                if (rd) model_dout = model_mem[a[7:0]];
                else    model_mem[a[7:0]] = d;
            end
            exp_err = en && (a[15:8] != 8'h00);
            $display("rnd %0d en=%0b rd=%0b addr=%h din=%h dout=%h err=%0b", i, en, rd, a, d,
                     bus.DMem_dout, bus.addr_err);
            chk("rnd_dout", bus.DMem_dout, model_dout);
            chk("rnd_err", {15'd0, bus.addr_err}, {15'd0, exp_err});
        end

`ifdef DMEM_CLEAR_EN
        // Reset mid-sweep: sweep restarts, old contents are destroyed.
        do_cycle(1'b1, 1'b0, 16'h0003, 16'h7777);
        pulse_reset(1);
        repeat (100) @(posedge clock);
        pulse_reset(1);
        #1;
        wait_ready(n);
        chk("restart_len", 16'(n), 16'd256);
        do_cycle(1'b1, 1'b1, 16'h0003, 16'h0000);
        chk("restart_0003", bus.DMem_dout, 16'h0000);
        $display("restart sweep edges=%0d dout=%h", n, bus.DMem_dout);
`else
        pulse_reset(1);
        #1;
        chk("rereset_dout", bus.DMem_dout, 16'h0000);
        chk("rereset_ready", {15'd0, bus.dmem_ready}, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
